cotm32_zicsr_unit: RTL and testbench
====================================

Name: cotm32_zicsr_unit

Overview:
- Machine-mode CSR responder and trap sequencer for cotm32.
- Owns the mtvec, mepc, mcause and mtval registers.
- Services Zicsr read-modify-write requests from the execute stage over a valid/ready handshake.
- On trap entry, captures the trap state and issues a one-cycle PC redirect to mtvec; on mret, issues a redirect to mepc.

Parameters:
- MXLEN, 32, register width; taken from cotm32_priv_pkg.
- RESET_MTVEC, 32'h0000_0000, reset value of mtvec; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- csr_req_valid  in  1  CSR request valid
- csr_req_ready  out  1  CSR request accept
- csr_op  in  2  zicsr_csr_op_t: NONE/RW/RS/RC
- csr_addr  in  12  CSR address
- csr_wdata  in  MXLEN  operand, already selected from rs1 or zero-extended imm
- csr_rsp_valid  out  1  response strobe
- csr_rdata  out  MXLEN  old CSR value
- csr_illegal  out  1  response flag: unimplemented address
- trap_req  in  1  trap entry request
- trap_cause  in  MXLEN  trap_cause_t
- trap_pc  in  MXLEN  PC of the faulting instruction
- trap_val  in  MXLEN  mtval payload
- mret_req  in  1  mret request
- redirect_valid  out  1  PC redirect strobe
- redirect_pc  out  MXLEN  redirect target

Behaviour:
- Reset (synchronous, active-high):
  - mtvec=RESET_MTVEC; mepc, mcause, mtval = 0.
  - FSM to IDLE.
  - All outputs 0, except csr_req_ready, which follows its rule below.
- FSM states:
  - IDLE: on trap_req or mret_req, go to REDIRECT.
  - REDIRECT: one cycle, then return to IDLE unconditionally.
- Priority in IDLE: trap_req > mret_req > CSR request.
- csr_req_ready = (state==IDLE) && !trap_req && !mret_req. This is combinational; a CSR request coincident with a trap or mret is not accepted and must be held.
- CSR accept (valid && ready at edge N):
  - Write applied at edge N, with old = current value:
    - RW: new = wdata.
    - RS: new = old | wdata.
    - RC: new = old & ~wdata.
    - NONE: no write.
  - Cycle N+1: csr_rsp_valid=1 for exactly one cycle, csr_rdata = old value, csr_illegal=0.
  - Latency is 1 cycle. Back-to-back accepts are allowed every cycle, and each response reflects the preceding write.
- Unimplemented address: no write; response has csr_rdata=0 and csr_illegal=1.
- WARL rules:
  - mtvec[1:0] always 0 (direct mode only).
  - mepc[1:0] always 0.
  - mcause and mtval are full-width writable.
- Trap entry (trap_req in IDLE at edge N):
  - mepc <= trap_pc & ~3; mcause <= trap_cause; mtval <= trap_val.
  - Cycle N+1: redirect_valid=1, redirect_pc = mtvec as of edge N.
  - A CSR write accepted at edge N-1 is visible to the trap (mtvec in use is post-write).
- mret (mret_req in IDLE, no trap_req): no register change; cycle N+1: redirect_valid=1, redirect_pc = mepc.
- In REDIRECT:
  - trap_req and mret_req are ignored; the pipeline flushes on the redirect.
  - An outstanding CSR response from the previous cycle is still delivered.
- redirect_valid is high only in REDIRECT; redirect_pc is 0 when not valid.
- Reset during REDIRECT: state IDLE, and redirect_valid and csr_rsp_valid are 0 on the next cycle.
- The bench asserts that trap_req and mret_req are never both high.

Decomposition:
- Add to cotm32_priv_pkg:
  - zicsr_state_t {ZICSR_ST_IDLE, ZICSR_ST_REDIRECT}.
  - Localparam ZICSR_MTVEC_MODE_MASK = 32'hFFFF_FFFC.
- Reuse the existing trap_cause_t, zicsr_csr_addr_t and zicsr_csr_op_t.
- One natural sub-module: cotm32_zicsr_rmw. It is purely combinational: old, wdata, op -> new value, write enable.
- Register storage and the FSM stay in the top.

Test Plan:
- After reset, CSRRS x0 on mtvec (op RS, wdata 0) -> rsp next cycle: rdata=RESET_MTVEC, illegal=0, mtvec unchanged.
- RW mtvec 0x8000_0103, then RS mcause 0xF0, then RC mcause 0x30 back-to-back -> responses rdata 0x0 (mtvec old), 0x0, 0xF0; final mtvec=0x8000_0100, mcause=0xC0.
- With mtvec=0x8000_0100, trap_req cause=11, pc=0x0000_0246, val=0 -> next cycle redirect_valid=1, redirect_pc=0x8000_0100; mepc=0x0000_0244, mcause=11, mtval=0.
- mret_req with mepc=0x0000_0244 -> next cycle redirect_pc=0x0000_0244; csr_req_ready=0 during the mret cycle and the REDIRECT cycle.
- csr_req_valid with trap_req in the same cycle (RW mtval 0x55) -> not accepted, trap taken; the held request is accepted after REDIRECT, and its rsp rdata equals the trap_val written by the trap.
- Access to address 0x300 with op RW -> rsp illegal=1, rdata=0, no CSR changes; assert rst during REDIRECT -> no redirect_valid the next cycle, all CSRs back to reset values.

Source files
------------

// File: rtl/cotm32_priv_pkg.sv
// Machine-mode privilege definitions shared by cotm32 CSR and trap logic.
package cotm32_priv_pkg;

    localparam int unsigned MXLEN = 32;

    typedef logic [MXLEN-1:0] trap_cause_t;

    typedef enum logic [1:0] {
        ZICSR_OP_NONE = 2'd0,
        ZICSR_OP_RW   = 2'd1,
        ZICSR_OP_RS   = 2'd2,
        ZICSR_OP_RC   = 2'd3
    } zicsr_csr_op_t;

    typedef enum logic [11:0] {
        CSR_MTVEC  = 12'h305,
        CSR_MEPC   = 12'h341,
        CSR_MCAUSE = 12'h342,
        CSR_MTVAL  = 12'h343
    } zicsr_csr_addr_t;

    typedef enum logic {
        ZICSR_ST_IDLE,
        ZICSR_ST_REDIRECT
    } zicsr_state_t;

    // Clears the two low bits: direct-mode mtvec, and word-aligned mepc.
    localparam logic [MXLEN-1:0] ZICSR_MTVEC_MODE_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cotm32_zicsr_rmw.sv
// Zicsr read-modify-write datapath: computes the new CSR value and write enable.
module cotm32_zicsr_rmw
    import cotm32_priv_pkg::*;
(
    input  logic [MXLEN-1:0] old_val,
    input  logic [MXLEN-1:0] wdata,
    input  logic [1:0]       op,
    output logic [MXLEN-1:0] new_val,
    output logic             we
);

    // Apply the selected operation; NONE is a pure read.
    always_comb begin
        new_val = old_val;
        we      = 1'b0;
        unique case (zicsr_csr_op_t'(op))
            ZICSR_OP_RW: begin
                new_val = wdata;
                we      = 1'b1;
            end
            ZICSR_OP_RS: begin
                new_val = old_val | wdata;
                we      = 1'b1;
            end
            ZICSR_OP_RC: begin
                new_val = old_val & ~wdata;
                we      = 1'b1;
            end
            default: begin
                new_val = old_val;
                we      = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/cotm32_zicsr_unit.sv
// Machine-mode CSR responder and trap/mret redirect sequencer for cotm32.
module cotm32_zicsr_unit
    import cotm32_priv_pkg::*;
#(
    parameter logic [MXLEN-1:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             csr_req_valid,
    output logic             csr_req_ready,
    input  logic [1:0]       csr_op,
    input  logic [11:0]      csr_addr,
    input  logic [MXLEN-1:0] csr_wdata,
    output logic             csr_rsp_valid,
    output logic [MXLEN-1:0] csr_rdata,
    output logic             csr_illegal,
    input  logic             trap_req,
    input  logic [MXLEN-1:0] trap_cause,
    input  logic [MXLEN-1:0] trap_pc,
    input  logic [MXLEN-1:0] trap_val,
    input  logic             mret_req,
    output logic             redirect_valid,
    output logic [MXLEN-1:0] redirect_pc
);

    zicsr_state_t     state_q, state_d;
    logic [MXLEN-1:0] mtvec_q, mepc_q, mtval_q;
    trap_cause_t      mcause_q;
    logic             rsp_valid_q, rsp_illegal_q;
    logic [MXLEN-1:0] rsp_rdata_q;
    logic [MXLEN-1:0] redirect_pc_q;

    logic             in_idle, take_trap, take_mret, csr_accept;
    logic             sel_mtvec, sel_mepc, sel_mcause, sel_mtval, csr_hit;
    logic [MXLEN-1:0] csr_old, csr_new;
    logic             rmw_we, csr_wr;

    assign in_idle    = (state_q == ZICSR_ST_IDLE);
    assign take_trap  = in_idle && trap_req;
    assign take_mret  = in_idle && !trap_req && mret_req;
    // Traps and mret outrank CSR traffic; a coincident request must be held.
    assign csr_req_ready = in_idle && !trap_req && !mret_req;
    assign csr_accept    = csr_req_valid && csr_req_ready;

    // Decode the CSR address and select the current value.
    always_comb begin
        sel_mtvec  = 1'b0;
        sel_mepc   = 1'b0;
        sel_mcause = 1'b0;
        sel_mtval  = 1'b0;
        csr_old    = '0;
        case (csr_addr)
            CSR_MTVEC: begin
                sel_mtvec = 1'b1;
                csr_old   = mtvec_q;
            end
            CSR_MEPC: begin
                sel_mepc = 1'b1;
                csr_old  = mepc_q;
            end
            CSR_MCAUSE: begin
                sel_mcause = 1'b1;
                csr_old    = mcause_q;
            end
            CSR_MTVAL: begin
                sel_mtval = 1'b1;
                csr_old   = mtval_q;
            end
            default: csr_old = '0;
        endcase
    end

    assign csr_hit = sel_mtvec | sel_mepc | sel_mcause | sel_mtval;

    cotm32_zicsr_rmw u_rmw (
        .old_val (csr_old),
        .wdata   (csr_wdata),
        .op      (csr_op),
        .new_val (csr_new),
        .we      (rmw_we)
    );

    assign csr_wr = csr_accept && csr_hit && rmw_we;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ZICSR_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: REDIRECT always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ZICSR_ST_IDLE: begin
                if (trap_req || mret_req) begin
                    state_d = ZICSR_ST_REDIRECT;
                end
            end
            ZICSR_ST_REDIRECT: state_d = ZICSR_ST_IDLE;
            default:           state_d = ZICSR_ST_IDLE;
        endcase
    end

    // CSR storage; trap capture and CSR writes never coincide since ready drops on a trap.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtvec_q  <= RESET_MTVEC & ZICSR_MTVEC_MODE_MASK;
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (take_trap) begin
            mepc_q   <= trap_pc & ZICSR_MTVEC_MODE_MASK;
            mcause_q <= trap_cause;
            mtval_q  <= trap_val;
        end else if (csr_wr) begin
            if (sel_mtvec)  mtvec_q  <= csr_new & ZICSR_MTVEC_MODE_MASK;
            if (sel_mepc)   mepc_q   <= csr_new & ZICSR_MTVEC_MODE_MASK;
            if (sel_mcause) mcause_q <= csr_new;
            if (sel_mtval)  mtval_q  <= csr_new;
        end
    end

    // One-cycle response carrying the pre-write value, or an illegal flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            rsp_valid_q   <= csr_accept;
            rsp_rdata_q   <= (csr_accept && csr_hit) ? csr_old : '0;
            rsp_illegal_q <= csr_accept && !csr_hit;
        end
    end

    // Latch the redirect target as seen at the trap/mret edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_pc_q <= '0;
        end else if (take_trap) begin
            redirect_pc_q <= mtvec_q;
        end else if (take_mret) begin
            redirect_pc_q <= mepc_q;
        end
    end

    assign csr_rsp_valid  = rsp_valid_q;
    assign csr_rdata      = rsp_rdata_q;
    assign csr_illegal    = rsp_illegal_q;
    assign redirect_valid = (state_q == ZICSR_ST_REDIRECT);
    assign redirect_pc    = redirect_valid ? redirect_pc_q : '0;

endmodule

// File: tb/tb_cotm32_zicsr_unit.sv
// Self-checking bench for cotm32_zicsr_unit: vector table plus trap/mret sequences.
module tb_cotm32_zicsr_unit;

    localparam logic [1:0]  OP_NONE = 2'd0;
    localparam logic [1:0]  OP_RW   = 2'd1;
    localparam logic [1:0]  OP_RS   = 2'd2;
    localparam logic [1:0]  OP_RC   = 2'd3;
    localparam logic [11:0] A_MTVEC  = 12'h305;
    localparam logic [11:0] A_MEPC   = 12'h341;
    localparam logic [11:0] A_MCAUSE = 12'h342;
    localparam logic [11:0] A_MTVAL  = 12'h343;
    localparam logic [11:0] A_BAD    = 12'h300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        csr_req_valid = 1'b0;
    logic        csr_req_ready;
    logic [1:0]  csr_op = 2'd0;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic        csr_rsp_valid;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req = 1'b0;
    logic [31:0] trap_cause = 32'd0;
    logic [31:0] trap_pc = 32'd0;
    logic [31:0] trap_val = 32'd0;
    logic        mret_req = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    cotm32_zicsr_unit dut (
        .clk            (clk),
        .rst            (rst),
        .csr_req_valid  (csr_req_valid),
        .csr_req_ready  (csr_req_ready),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rsp_valid  (csr_rsp_valid),
        .csr_rdata      (csr_rdata),
        .csr_illegal    (csr_illegal),
        .trap_req       (trap_req),
        .trap_cause     (trap_cause),
        .trap_pc        (trap_pc),
        .trap_val       (trap_val),
        .mret_req       (mret_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        ill;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        ill;
    } exp_t;

    vec_t        vt[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    int          exp_redir_cyc = -1;
    logic [31:0] exp_redir_pc = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [11:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic ill);
        vec_t v;
        v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.ill = ill;
        return v;
    endfunction

    // Response and redirect monitor, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rsp_valid", {31'd0, csr_rsp_valid}, 32'd1);
                check("rsp_rdata", csr_rdata, e.rdata);
                check("rsp_illegal", {31'd0, csr_illegal}, {31'd0, e.ill});
            end else begin
                check("rsp_idle", {31'd0, csr_rsp_valid}, 32'd0);
            end
            if (cyc == exp_redir_cyc) begin
                check("redirect_valid", {31'd0, redirect_valid}, 32'd1);
                check("redirect_pc", redirect_pc, exp_redir_pc);
            end else begin
                check("redirect_idle", {31'd0, redirect_valid}, 32'd0);
                check("redirect_pc_zero", redirect_pc, 32'd0);
            end
        end
    end

    // The bench never drives trap and mret together.
    always @(negedge clk) assert (!(trap_req && mret_req));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_step(input vec_t v);
        csr_req_valid = 1'b1;
        csr_op        = v.op;
        csr_addr      = v.addr;
        csr_wdata     = v.wdata;
        @(negedge clk);
        check("req_ready", {31'd0, csr_req_ready}, 32'd1);
        if (csr_req_ready) sb.push_back('{cyc + 1, v.rdata, v.ill});
        step();
    endtask

    task automatic run_vec(input int lo, input int hi);
        for (int i = lo; i < hi; i++) req_step(vt[i]);
        csr_req_valid = 1'b0;
    endtask

    // Trap or mret followed by the REDIRECT cycle; any driven CSR request stays held.
    task automatic event_step(input bit is_trap, input logic [31:0] cause,
                              input logic [31:0] pc, input logic [31:0] val,
                              input logic [31:0] exp_pc);
        trap_req   = is_trap;
        mret_req   = !is_trap;
        trap_cause = cause;
        trap_pc    = pc;
        trap_val   = val;
        @(negedge clk);
        check("ready_in_event", {31'd0, csr_req_ready}, 32'd0);
        exp_redir_cyc = cyc + 1;
        exp_redir_pc  = exp_pc;
        step();
        trap_req = 1'b0;
        mret_req = 1'b0;
        @(negedge clk);
        check("ready_in_redirect", {31'd0, csr_req_ready}, 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, b1, c0, c1, d1, e1;
        a0 = 0;
        vt.push_back(mk(OP_RS,   A_MTVEC,  32'h0,          32'h0,          1'b0));
        vt.push_back(mk(OP_RW,   A_MTVEC,  32'h8000_0103,  32'h0,          1'b0));
        vt.push_back(mk(OP_RS,   A_MCAUSE, 32'hF0,         32'h0,          1'b0));
        vt.push_back(mk(OP_RC,   A_MCAUSE, 32'h30,         32'hF0,         1'b0));
        vt.push_back(mk(OP_RS,   A_MTVEC,  32'h0,          32'h8000_0100,  1'b0));
        vt.push_back(mk(OP_RS,   A_MCAUSE, 32'h0,          32'hC0,         1'b0));
        vt.push_back(mk(OP_RW,   A_MEPC,   32'h1237,       32'h0,          1'b0));
        vt.push_back(mk(OP_RC,   A_MEPC,   32'h0,          32'h1234,       1'b0));
        vt.push_back(mk(OP_RW,   A_MTVAL,  32'hDEAD_BEEF,  32'h0,          1'b0));
        vt.push_back(mk(OP_NONE, A_MTVAL,  32'h123,        32'hDEAD_BEEF,  1'b0));
        vt.push_back(mk(OP_RW,   A_MTVAL,  32'h1,          32'hDEAD_BEEF,  1'b0));
        vt.push_back(mk(OP_RW,   A_BAD,    32'hFFFF,       32'h0,          1'b1));
        vt.push_back(mk(OP_RS,   A_MTVAL,  32'h0,          32'h1,          1'b0));
        a1 = vt.size();
        vt.push_back(mk(OP_RS,   A_MEPC,   32'h0,          32'h244,        1'b0));
        vt.push_back(mk(OP_RS,   A_MCAUSE, 32'h0,          32'd11,         1'b0));
        vt.push_back(mk(OP_RS,   A_MTVAL,  32'h0,          32'h0,          1'b0));
        b1 = vt.size();
        vt.push_back(mk(OP_RS,   A_MEPC,   32'h0,          32'h244,        1'b0));
        c0 = vt.size();
        vt.push_back(mk(OP_RW,   A_MTVAL,  32'h55,         32'hABCD,       1'b0));
        vt.push_back(mk(OP_RS,   A_MTVAL,  32'h0,          32'h55,         1'b0));
        vt.push_back(mk(OP_RS,   A_MEPC,   32'h0,          32'h300,        1'b0));
        vt.push_back(mk(OP_RS,   A_MCAUSE, 32'h0,          32'd2,          1'b0));
        c1 = vt.size();
        vt.push_back(mk(OP_RW,   A_MTVEC,  32'h2003,       32'h8000_0100,  1'b0));
        d1 = vt.size();
        vt.push_back(mk(OP_RS,   A_MTVEC,  32'h0,          32'h0,          1'b0));
        vt.push_back(mk(OP_RS,   A_MEPC,   32'h0,          32'h0,          1'b0));
        vt.push_back(mk(OP_RS,   A_MCAUSE, 32'h0,          32'h0,          1'b0));
        vt.push_back(mk(OP_RS,   A_MTVAL,  32'h0,          32'h0,          1'b0));
        e1 = vt.size();

        // Reset and check the idle state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'd0, csr_req_ready}, 32'd1);
        check("reset_rsp_valid", {31'd0, csr_rsp_valid}, 32'd0);
        check("reset_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        step();

        // Back-to-back CSR traffic, WARL, NONE and illegal address.
        run_vec(a0, a1);
        step();

        // Trap entry, then read back the captured state.
        event_step(1'b1, 32'd11, 32'h0000_0246, 32'h0, 32'h8000_0100);
        run_vec(a1, b1);

        // mret with a CSR request held across it.
        csr_req_valid = 1'b1;
        csr_op        = OP_RS;
        csr_addr      = A_MEPC;
        csr_wdata     = 32'h0;
        event_step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0000_0244);
        run_vec(b1, c0);

        // Trap coincident with a CSR write: the write waits and sees the trap's mtval.
        csr_req_valid = 1'b1;
        csr_op        = OP_RW;
        csr_addr      = A_MTVAL;
        csr_wdata     = 32'h55;
        event_step(1'b1, 32'd2, 32'h0000_0301, 32'hABCD, 32'h8000_0100);
        run_vec(c0, c1);

        // A write to mtvec on the cycle just before a trap sets the trap target.
        run_vec(c1, d1);
        event_step(1'b1, 32'd5, 32'h10, 32'h0, 32'h2000);

        // Reset asserted during REDIRECT.
        trap_req   = 1'b1;
        trap_cause = 32'd7;
        trap_pc    = 32'h20;
        trap_val   = 32'h9;
        @(negedge clk);
        exp_redir_cyc = cyc + 1;
        exp_redir_pc  = 32'h2000;
        step();
        trap_req = 1'b0;
        rst      = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_redirect", {31'd0, redirect_valid}, 32'd0);
        check("post_rst_ready", {31'd0, csr_req_ready}, 32'd1);
        step();
        run_vec(d1, e1);

        repeat (3) step();
        check("sb_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
